// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock_ctrl slice.
// Alarm states are compiled in only with CLOCK_CTRL_ALARM_EN.
package clock_ctrl_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef enum logic [2:0] {
    RUN         = 3'd0,
    SET_HOUR    = 3'd1,
`ifdef CLOCK_CTRL_ALARM_EN
    SET_MIN     = 3'd2,
    SET_AL_HOUR = 3'd3,
    SET_AL_MIN  = 3'd4
`else
    SET_MIN     = 3'd2
`endif
  } mode_t;

  function automatic logic [5:0] wrap_inc(
    input logic [5:0] v,
    input logic [5:0] max
  );
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick marks the last count.
// clr restarts the count synchronously.
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr || count == LAST)
      count <= '0;
    else
      count <= count + W'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/clock_ctrl.sv
// 24h clock with set modes; optional alarm via CLOCK_CTRL_ALARM_EN.
// All field updates land on the edge that samples the button/tick.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_btn,
  input  logic              inc_btn,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [2:0]        mode_state,
`ifdef CLOCK_CTRL_ALARM_EN
  output logic              alarm,
`endif
  output logic              sec_tick
);

  mode_t state, state_n;

  logic ret_run;
  logic edit;
  logic run_tick;
  logic hour_edit;
  logic min_edit;

  logic [SEC_W-1:0]  sec_inc;
  logic [MIN_W-1:0]  min_inc;
  logic [HOUR_W-1:0] hour_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RUN;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (mode_btn) begin
      unique case (state)
        RUN:         state_n = SET_HOUR;
        SET_HOUR:    state_n = SET_MIN;
`ifdef CLOCK_CTRL_ALARM_EN
        SET_MIN:     state_n = SET_AL_HOUR;
        SET_AL_HOUR: state_n = SET_AL_MIN;
        SET_AL_MIN:  state_n = RUN;
`else
        SET_MIN:     state_n = RUN;
`endif
        default:     state_n = RUN;
      endcase
    end
  end

  assign mode_state = state;

  // mode_btn always beats a simultaneous inc_btn
  assign edit      = inc_btn && !mode_btn;
  assign ret_run   = mode_btn && state != RUN
                  && state_n == RUN;
  assign run_tick  = state == RUN && sec_tick;
  assign hour_edit = state == SET_HOUR && edit;
  assign min_edit  = state == SET_MIN && edit;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (ret_run),
    .tick (sec_tick)
  );

  always_comb begin
    sec_inc  = wrap_inc(sec, SEC_MAX);
    min_inc  = wrap_inc(min, MIN_MAX);
    hour_inc = (hour >= HOUR_MAX)
             ? '0 : hour + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec  <= '0;
      min  <= '0;
      hour <= '0;
    end else if (ret_run) begin
      sec <= '0;
    end else begin
      unique case (1'b1)
        run_tick: begin
          sec <= sec_inc;
          if (sec == SEC_MAX) begin
            min <= min_inc;
            if (min == MIN_MAX)
              hour <= hour_inc;
          end
        end
        hour_edit: hour <= hour_inc;
        min_edit:  min  <= min_inc;
        default: ;
      endcase
    end
  end

`ifdef CLOCK_CTRL_ALARM_EN
  logic [MIN_W-1:0]  al_min;
  logic [HOUR_W-1:0] al_hour;
  logic [5:0]        al_cnt;
  logic              al_hit;

  // time is about to become al_hour:al_min:00
  assign al_hit = run_tick && sec == SEC_MAX
               && ((min == MIN_MAX)
                   ? (hour_inc == al_hour
                      && al_min == '0)
                   : (hour == al_hour
                      && min_inc == al_min));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      al_min  <= '0;
      al_hour <= '0;
      al_cnt  <= '0;
      alarm   <= 1'b0;
    end else begin
      if (state == SET_AL_HOUR && edit)
        al_hour <= (al_hour >= HOUR_MAX)
                 ? '0 : al_hour + 5'd1;
      if (state == SET_AL_MIN && edit)
        al_min <= wrap_inc(al_min, MIN_MAX);
      if (mode_btn || inc_btn) begin
        alarm  <= 1'b0;
        al_cnt <= '0;
      end else if (al_hit) begin
        alarm  <= 1'b1;
        al_cnt <= '0;
      end else if (alarm && sec_tick) begin
        if (al_cnt == 6'd59)
          alarm <= 1'b0;
        al_cnt <= al_cnt + 6'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl at TICK_DIV=4.
// Alarm checks build only with CLOCK_CTRL_ALARM_EN.
module tb_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_btn;
  logic       inc_btn;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [2:0] mode_state;
  logic       sec_tick;
`ifdef CLOCK_CTRL_ALARM_EN
  logic       alarm;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ticks;
  int cur_min;

  always #5 clk = ~clk;

  clock_ctrl #(
    .TICK_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_btn   (mode_btn),
    .inc_btn    (inc_btn),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .mode_state (mode_state),
`ifdef CLOCK_CTRL_ALARM_EN
    .alarm      (alarm),
`endif
    .sec_tick   (sec_tick)
  );

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    mode_btn = 1'b1;
    step(1);
    mode_btn = 1'b0;
  endtask

  task automatic inc_n(input int n);
    if (n > 0) begin
      inc_btn = 1'b1;
      step(n);
      inc_btn = 1'b0;
    end
  endtask

  task automatic check_time(
    input string tag,
    input int h,
    input int m,
    input int s
  );
    check({tag, ".hour"}, 32'(hour), h);
    check({tag, ".min"},  32'(min),  m);
    check({tag, ".sec"},  32'(sec),  s);
  endtask

  initial begin
    rst      = 1'b1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    step(2);
    check_time("reset", 0, 0, 0);
    check("reset.mode", 32'(mode_state), 0);
    check("reset.tick", 32'(sec_tick), 0);
`ifdef CLOCK_CTRL_ALARM_EN
    check("reset.alarm", 32'(alarm), 0);
`endif
    rst = 1'b0;

    step(3);
    check("edge3.sec", 32'(sec), 0);
    check("edge3.tick", 32'(sec_tick), 1);
    step(1);
    check("edge4.sec", 32'(sec), 1);
    check("edge4.tick", 32'(sec_tick), 0);
    step(4);
    check("edge8.sec", 32'(sec), 2);

    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (sec_tick) ticks++;
    end
    check("tick_rate", ticks, 4);
    check("edge24.sec", 32'(sec), 6);

    inc_n(1);
    check("run_inc.hour", 32'(hour), 0);
    check("run_inc.min", 32'(min), 0);

    pulse_mode();
    check("set_hour.mode", 32'(mode_state), 1);
    inc_n(23);
    check("set_hour.h23", 32'(hour), 23);
    check("set_hour.frozen", 32'(sec), 6);
    inc_n(1);
    check("hour_wrap", 32'(hour), 0);
    inc_n(23);

    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    step(1);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    check("both.mode", 32'(mode_state), 2);
    check("both.hour", 32'(hour), 23);

    inc_n(59);
    check("set_min.m59", 32'(min), 59);
    inc_n(1);
    check("min_wrap.min", 32'(min), 0);
    check("min_wrap.hour", 32'(hour), 23);
    inc_n(59);

`ifdef CLOCK_CTRL_ALARM_EN
    pulse_mode();
    check("al_hour.mode", 32'(mode_state), 3);
    pulse_mode();
    check("al_min.mode", 32'(mode_state), 4);
    inc_n(1);
    check("al_edit.min", 32'(min), 59);
`endif
    pulse_mode();
    check("ret_run.mode", 32'(mode_state), 0);
    check("ret_run.sec", 32'(sec), 0);
    check("ret_run.tick", 32'(sec_tick), 0);

    step(239);
    check_time("pre_roll", 23, 59, 59);
    step(1);
    check_time("roll", 0, 0, 0);

`ifdef CLOCK_CTRL_ALARM_EN
    step(239);
    check("alarm.pre", 32'(alarm), 0);
    step(1);
    check("alarm.rise", 32'(alarm), 1);
    check_time("alarm.time", 0, 1, 0);
    inc_n(1);
    check("alarm.clear", 32'(alarm), 0);
    check("alarm.min", 32'(min), 1);
    cur_min = 1;
`else
    cur_min = 0;
`endif

    pulse_mode();
    inc_n(5);
    pulse_mode();
    check("pre_rst.mode", 32'(mode_state), 2);
    inc_n(30 - cur_min);
    check("pre_rst.min", 32'(min), 30);
    check("pre_rst.hour", 32'(hour), 5);
    rst = 1'b1;
    #1;
    check_time("async_rst", 0, 0, 0);
    check("async_rst.mode", 32'(mode_state), 0);
    check("async_rst.tick", 32'(sec_tick), 0);
    step(1);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
- REQ-001: Parameter TICK_DIV SHALL be declared with default 100000000; it sets the clk cycles per one-second tick, legal range ≥2.
- REQ-002: clk  input  1  SHALL be the sole clock, rising-edge active.
- REQ-003: rst  input  1  SHALL be an asynchronous, active-high reset.
- REQ-004: mode_btn  input  1  SHALL be a one-cycle, debounced pulse that advances the mode FSM.
- REQ-005: inc_btn  input  1  SHALL be a one-cycle, debounced pulse that increments the field selected in a set state.
- REQ-006: sec  output  6  SHALL carry seconds, 0..59.
- REQ-007: min  output  6  SHALL carry minutes, 0..59.
- REQ-008: hour  output  5  SHALL carry hours, 0..23.
- REQ-009: mode_state  output  3  SHALL carry the current FSM state encoding.
- REQ-010: sec_tick  output  1  SHALL be high for one cycle when the prescaler wraps.
- REQ-011: alarm  output  1  SHALL indicate an active alarm; the port exists only with CLOCK_CTRL_ALARM_EN.

Function
- REQ-012: Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0.
  - sec_tick = (count == TICK_DIV-1), combinational from the prescaler register.
- REQ-013: FSM states SHALL be encoded RUN=0, SET_HOUR=1, SET_MIN=2, SET_AL_HOUR=3, SET_AL_MIN=4.
  - mode_btn sequence: RUN->SET_HOUR->SET_MIN->RUN.
  - With ALARM_EN: SET_MIN->SET_AL_HOUR->SET_AL_MIN->RUN.
- REQ-014: In RUN, on an edge with sec_tick=1, sec SHALL increment.
  - sec 59->0 with a carry into min.
  - min 59->0 with a carry into hour.
  - hour 23->0.
  - All carries resolve on the same edge; 23:59:59 -> 00:00:00 in one cycle.
- REQ-015: In any set state, time counting SHALL halt; sec_tick is still generated but ignored.
- REQ-016: inc_btn in SET_HOUR SHALL increment hour, 23->0, with no carry.
- REQ-017: inc_btn in SET_MIN SHALL increment min, 59->0, with no carry into hour.
- REQ-018: inc_btn in RUN SHALL be ignored.
- REQ-019: The mode_btn transition that returns to RUN SHALL clear sec to 0 and the prescaler to 0 on the same edge.
  - The first subsequent tick occurs TICK_DIV cycles later.
- REQ-020: If mode_btn and inc_btn are high in the same cycle, mode_btn SHALL win; the increment is discarded.
- REQ-021: Field updates SHALL take effect on the edge where the triggering input is sampled; outputs are registered with zero extra latency.

Reset
- REQ-022: While rst is high, outputs SHALL be forced immediately (asynchronous):
  - sec=0, min=0, hour=0, mode_state=RUN, prescaler=0;
  - alarm=0, alarm_hour=0, alarm_min=0 when ALARM_EN is defined.
- REQ-023: Reset asserted mid-set SHALL discard partial edits and return the FSM to RUN.
- REQ-024: The first tick after reset release SHALL occur on the TICK_DIV-th rising edge.

Configuration
- REQ-025: Macro CLOCK_CTRL_ALARM_EN, when defined, SHALL add:
  - internal registers alarm_hour/alarm_min, edited in SET_AL_HOUR/SET_AL_MIN with the same wrap rules;
  - the alarm output, set on the RUN edge where the time becomes alarm_hour:alarm_min:00;
  - alarm clear on any mode_btn/inc_btn pulse, or after 60 ticks.
- REQ-026: Without CLOCK_CTRL_ALARM_EN, the alarm port, alarm registers and states 3/4 SHALL be absent; mode_state never exceeds 2.

Structure
- REQ-027: Package clock_ctrl_pkg SHALL hold:
  - the state enum type;
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
  - width constants 6/6/5.
- REQ-028: Sub-module tick_prescaler SHALL implement REQ-012.
  - Inputs: clk, rst, clr.
  - Output: tick.
  - Parameter: TICK_DIV.

Verification
- REQ-029: TICK_DIV=4, release reset -> sec=1 after the 4th edge, sec=2 after the 8th; sec_tick high one cycle in every 4.
- REQ-030: Set hour to 23 (mode, 23 inc), then min to 59, mode back to RUN -> after 240 cycles 23:59:59->00:00:00 on a single edge.
- REQ-031: In SET_MIN with min=59, inc -> min=0, hour unchanged; in SET_HOUR with hour=23, inc -> hour=0.
- REQ-032: mode_btn and inc_btn together in SET_HOUR -> state=SET_MIN, hour unchanged.
- REQ-033: Assert rst mid-SET_MIN with min=30 -> all outputs 0 and mode_state=0 before the next edge.
- REQ-034: ALARM_EN, alarm 00:01, start at 00:00:00 in RUN, TICK_DIV=4 -> alarm rises after 240 cycles; an inc_btn pulse clears it on the next edge.
